// File: rtl/mult_div_unit_if.sv
// Request/result bundle between MIPS control/register file and the HI/LO multiply-divide unit.
interface mult_div_unit_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] rs_data;
  logic [WIDTH-1:0] rt_data;
  logic             busy;
  logic             done;
  logic             div_by_zero;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, rs_data, rt_data,
    input  busy, done, div_by_zero, hi, lo
  );

  modport slave (
    input  start, op, rs_data, rt_data,
    output busy, done, div_by_zero, hi, lo
  );
endinterface

// File: rtl/mult_div_unit.sv
// Iterative shift-add multiplier / restoring divider owning the architectural HI/LO pair.
// Operands are reduced to magnitudes up front; signs are re-applied in a single FIX cycle.
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  mult_div_unit_if.slave       bus
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  localparam logic [2:0] OP_MTHI = 3'b100;
  localparam logic [2:0] OP_MTLO = 3'b101;

  typedef enum logic [2:0] {
    S_IDLE,
    S_MUL,
    S_DIV,
    S_FIX,
    S_DZ
  } state_t;

  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   dbz_q, dbz_d;
  logic [WIDTH-1:0]       hi_q, hi_d;
  logic [WIDTH-1:0]       lo_q, lo_d;

  logic [2*WIDTH-1:0]     acc_q, acc_d;
  logic [WIDTH-1:0]       opb_q, opb_d;
  logic                   neg_res_q, neg_res_d;
  logic                   neg_rem_q, neg_rem_d;
  logic                   is_div_q, is_div_d;

  function automatic logic [WIDTH-1:0] magnitude(input logic signed [WIDTH-1:0] v,
                                                 input logic                     sgn);
    logic signed [WIDTH-1:0] neg_v;
    neg_v = -v;
    return (sgn && v[WIDTH-1]) ? $unsigned(neg_v) : $unsigned(v);
  endfunction

  function automatic logic [WIDTH-1:0] apply_sign(input logic [WIDTH-1:0] v, input logic neg);
    return neg ? (~v + WIDTH'(1)) : v;
  endfunction

  logic             accept;
  logic             op_arith;
  logic             op_signed;
  logic             op_div;
  logic             rt_zero;
  logic             last_step;
  logic [WIDTH-1:0] rs_mag;
  logic [WIDTH-1:0] rt_mag;

  assign accept    = bus.start && !busy_q;
  assign op_arith  = !bus.op[2];
  assign op_signed = !bus.op[0];
  assign op_div    = bus.op[1];
  assign rt_zero   = (bus.rt_data == '0);
  assign last_step = (cnt_q == CNT_W'(WIDTH - 1));
  assign rs_mag    = magnitude(bus.rs_data, op_signed);
  assign rt_mag    = magnitude(bus.rt_data, op_signed);

  // Shift-add step: add multiplicand into the upper half when the multiplier LSB is set, then shift right.
  logic [WIDTH:0]       mul_sum;
  logic [2*WIDTH-1:0]   mul_next;
  assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opb_q} : '0);
  assign mul_next = {mul_sum, acc_q[WIDTH-1:1]};

  // Restoring step: acc holds {remainder, dividend/quotient}; quotient bits enter from the right.
  logic [WIDTH:0]       rem_sh;
  logic [WIDTH:0]       div_diff;
  logic                 q_bit;
  logic [2*WIDTH-1:0]   div_next;
  assign rem_sh   = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
  assign div_diff = rem_sh - {1'b0, opb_q};
  assign q_bit    = !div_diff[WIDTH];
  assign div_next = {(q_bit ? div_diff[WIDTH-1:0] : rem_sh[WIDTH-1:0]), acc_q[WIDTH-2:0], q_bit};

  logic [2*WIDTH-1:0]   prod_fixed;
  assign prod_fixed = neg_res_q ? (~acc_q + (2*WIDTH)'(1)) : acc_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (accept && op_arith) begin
          if (op_div) state_d = rt_zero ? S_DZ : S_DIV;
          else        state_d = S_MUL;
        end
      end
      S_MUL:   if (last_step) state_d = S_FIX;
      S_DIV:   if (last_step) state_d = S_FIX;
      S_FIX:   state_d = S_IDLE;
      S_DZ:    state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    cnt_d     = cnt_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    dbz_d     = dbz_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    acc_d     = acc_q;
    opb_d     = opb_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    is_div_d  = is_div_q;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (op_arith) begin
            busy_d    = 1'b1;
            dbz_d     = 1'b0;
            cnt_d     = '0;
            is_div_d  = op_div;
            neg_res_d = op_signed && (bus.rs_data[WIDTH-1] ^ bus.rt_data[WIDTH-1]);
            neg_rem_d = op_signed && bus.rs_data[WIDTH-1];
            if (op_div) begin
              acc_d = {{WIDTH{1'b0}}, rs_mag};
              opb_d = rt_mag;
            end else begin
              acc_d = {{WIDTH{1'b0}}, rt_mag};
              opb_d = rs_mag;
            end
          end else if (bus.op == OP_MTHI) begin
            hi_d  = bus.rs_data;
            dbz_d = 1'b0;
          end else if (bus.op == OP_MTLO) begin
            lo_d  = bus.rs_data;
            dbz_d = 1'b0;
          end
        end
      end
      S_MUL: begin
        acc_d = mul_next;
        cnt_d = cnt_q + CNT_W'(1);
      end
      S_DIV: begin
        acc_d = div_next;
        cnt_d = cnt_q + CNT_W'(1);
      end
      S_FIX: begin
        busy_d = 1'b0;
        done_d = 1'b1;
        if (is_div_q) begin
          lo_d = apply_sign(acc_q[WIDTH-1:0], neg_res_q);
          hi_d = apply_sign(acc_q[2*WIDTH-1:WIDTH], neg_rem_q);
        end else begin
          hi_d = prod_fixed[2*WIDTH-1:WIDTH];
          lo_d = prod_fixed[WIDTH-1:0];
        end
      end
      S_DZ: begin
        busy_d = 1'b0;
        done_d = 1'b1;
        dbz_d  = 1'b1;
      end
      default: begin
        busy_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      dbz_q  <= 1'b0;
      hi_q   <= '0;
      lo_q   <= '0;
    end else begin
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
      done_q <= done_d;
      dbz_q  <= dbz_d;
      hi_q   <= hi_d;
      lo_q   <= lo_d;
    end
  end

  // Working operands are only meaningful between an accepted start and FIX, so they carry no reset.
  always_ff @(posedge clk) begin
    acc_q     <= acc_d;
    opb_q     <= opb_d;
    neg_res_q <= neg_res_d;
    neg_rem_q <= neg_rem_d;
    is_div_q  <= is_div_d;
  end

  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.div_by_zero = dbz_q;
  assign bus.hi          = hi_q;
  assign bus.lo          = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit: multiply, divide, HI/LO moves, divide-by-zero, busy and reset cases.
module tb_mult_div_unit;

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  mult_div_unit_if #(.WIDTH(32)) bus ();

  mult_div_unit #(.WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    bus.op      = o;
    bus.rs_data = a;
    bus.rt_data = b;
    bus.start   = 1'b1;
    @(negedge clk);
    bus.start   = 1'b0;
  endtask

  task automatic wait_idle(output int cyc);
    cyc = 0;
    while (bus.busy && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    bus.start = 1'b0; bus.op = 3'b000; bus.rs_data = '0; bus.rt_data = '0;
    repeat (3) @(negedge clk);
    checks++;
    if ({bus.busy, bus.done, bus.div_by_zero} !== 3'b000) begin
      errors++; $display("FAIL reset_ctrl got %b want 000", {bus.busy, bus.done, bus.div_by_zero});
    end
    checks++;
    if (bus.hi !== 32'h0 || bus.lo !== 32'h0) begin
      errors++; $display("FAIL reset_hilo got %h_%h want 0_0", bus.hi, bus.lo);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_multu;
    int cyc;
    issue(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_idle(cyc);
    checks++;
    if (cyc !== 33) begin errors++; $display("FAIL multu_latency got %0d want 33", cyc); end
    checks++;
    if (bus.done !== 1'b1) begin errors++; $display("FAIL multu_done got %b want 1", bus.done); end
    checks++;
    if (bus.hi !== 32'hFFFF_FFFE || bus.lo !== 32'h0000_0001) begin
      errors++; $display("FAIL multu_result got %h_%h want fffffffe_00000001", bus.hi, bus.lo);
    end
    @(negedge clk);
    checks++;
    if (bus.done !== 1'b0) begin errors++; $display("FAIL multu_done_pulse got %b want 0", bus.done); end
  endtask

  task automatic test_signed;
    int cyc;
    issue(OP_MULT, 32'hFFFF_FFFD, 32'd5);
    wait_idle(cyc);
    checks++;
    if (bus.hi !== 32'hFFFF_FFFF || bus.lo !== 32'hFFFF_FFF1) begin
      errors++; $display("FAIL mult_neg got %h_%h want ffffffff_fffffff1", bus.hi, bus.lo);
    end
    issue(OP_DIV, 32'hFFFF_FFF9, 32'd2);
    wait_idle(cyc);
    checks++;
    if (cyc !== 33) begin errors++; $display("FAIL div_latency got %0d want 33", cyc); end
    checks++;
    if (bus.lo !== 32'hFFFF_FFFD || bus.hi !== 32'hFFFF_FFFF) begin
      errors++; $display("FAIL div_neg_dividend got lo=%h hi=%h want lo=fffffffd hi=ffffffff", bus.lo, bus.hi);
    end
    issue(OP_DIV, 32'd7, 32'hFFFF_FFFE);
    wait_idle(cyc);
    checks++;
    if (bus.lo !== 32'hFFFF_FFFD || bus.hi !== 32'h0000_0001) begin
      errors++; $display("FAIL div_neg_divisor got lo=%h hi=%h want lo=fffffffd hi=00000001", bus.lo, bus.hi);
    end
  endtask

  task automatic test_div_zero;
    int cyc;
    issue(OP_MTHI, 32'h1234_5678, 32'h0);
    checks++;
    if (bus.hi !== 32'h1234_5678 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      errors++; $display("FAIL mthi got hi=%h busy=%b done=%b want 12345678/0/0", bus.hi, bus.busy, bus.done);
    end
    issue(OP_DIVU, 32'd10, 32'd0);
    wait_idle(cyc);
    checks++;
    if (cyc !== 1) begin errors++; $display("FAIL dz_latency got %0d want 1", cyc); end
    checks++;
    if (bus.done !== 1'b1 || bus.div_by_zero !== 1'b1) begin
      errors++; $display("FAIL dz_flags got done=%b dbz=%b want 1/1", bus.done, bus.div_by_zero);
    end
    checks++;
    if (bus.hi !== 32'h1234_5678) begin errors++; $display("FAIL dz_hi_kept got %h want 12345678", bus.hi); end
    @(negedge clk);
    checks++;
    if (bus.div_by_zero !== 1'b1) begin errors++; $display("FAIL dz_sticky got %b want 1", bus.div_by_zero); end
    issue(OP_MULTU, 32'd1, 32'd1);
    checks++;
    if (bus.div_by_zero !== 1'b0 || bus.busy !== 1'b1) begin
      errors++; $display("FAIL dz_clear got dbz=%b busy=%b want 0/1", bus.div_by_zero, bus.busy);
    end
    wait_idle(cyc);
  endtask

  task automatic test_busy_ignore;
    int cyc;
    issue(OP_DIVU, 32'd100, 32'd7);
    repeat (4) @(negedge clk);
    issue(OP_MULTU, 32'd2, 32'd3);
    checks++;
    if (bus.busy !== 1'b1) begin errors++; $display("FAIL ignore_busy got %b want 1", bus.busy); end
    wait_idle(cyc);
    checks++;
    if (cyc + 5 !== 33) begin errors++; $display("FAIL ignore_latency got %0d want 33", cyc + 5); end
    checks++;
    if (bus.lo !== 32'd14 || bus.hi !== 32'd2) begin
      errors++; $display("FAIL ignore_result got lo=%h hi=%h want lo=0000000e hi=00000002", bus.lo, bus.hi);
    end
    @(negedge clk);
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      errors++; $display("FAIL ignore_no_restart got busy=%b done=%b want 0/0", bus.busy, bus.done);
    end
  endtask

  task automatic test_overflow;
    int cyc;
    issue(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_idle(cyc);
    checks++;
    if (bus.lo !== 32'h8000_0000 || bus.hi !== 32'h0 || bus.div_by_zero !== 1'b0) begin
      errors++; $display("FAIL div_overflow got lo=%h hi=%h dbz=%b want 80000000/0/0", bus.lo, bus.hi, bus.div_by_zero);
    end
  endtask

  task automatic test_back_to_back;
    int cyc;
    issue(OP_MULTU, 32'd6, 32'd7);
    wait_idle(cyc);
    checks++;
    if (bus.done !== 1'b1 || bus.lo !== 32'd42 || bus.hi !== 32'd0) begin
      errors++; $display("FAIL b2b_first got done=%b lo=%h hi=%h want 1/0000002a/0", bus.done, bus.lo, bus.hi);
    end
    issue(OP_MULTU, 32'd3, 32'd5);
    checks++;
    if (bus.busy !== 1'b1) begin errors++; $display("FAIL b2b_accept got busy=%b want 1", bus.busy); end
    wait_idle(cyc);
    checks++;
    if (cyc !== 33 || bus.lo !== 32'd15 || bus.hi !== 32'd0) begin
      errors++; $display("FAIL b2b_second got cyc=%0d lo=%h hi=%h want 33/0000000f/0", cyc, bus.lo, bus.hi);
    end
  endtask

  task automatic test_noop;
    issue(3'b110, 32'hDEAD_BEEF, 32'd3);
    issue(3'b111, 32'hCAFE_F00D, 32'd3);
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.hi !== 32'd0 || bus.lo !== 32'd15) begin
      errors++; $display("FAIL noop got busy=%b done=%b hi=%h lo=%h want 0/0/0/0000000f", bus.busy, bus.done, bus.hi, bus.lo);
    end
  endtask

  task automatic test_reset_mid;
    bit saw_done;
    issue(OP_MTHI, 32'h0000_0055, 32'h0);
    issue(OP_MTLO, 32'h0000_00AA, 32'h0);
    checks++;
    if (bus.lo !== 32'hAA || bus.hi !== 32'h55) begin
      errors++; $display("FAIL mtlo got hi=%h lo=%h want 00000055/000000aa", bus.hi, bus.lo);
    end
    issue(OP_MULTU, 32'd4, 32'd4);
    repeat (9) @(negedge clk);
    checks++;
    if (bus.busy !== 1'b1) begin errors++; $display("FAIL mid_busy got %b want 1", bus.busy); end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (bus.hi !== 32'h0 || bus.lo !== 32'h0 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      errors++; $display("FAIL async_reset got hi=%h lo=%h busy=%b done=%b want 0/0/0/0", bus.hi, bus.lo, bus.busy, bus.done);
    end
    @(negedge clk);
    rst = 1'b0;
    saw_done = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.done || bus.busy) saw_done = 1'b1;
    end
    checks++;
    if (saw_done !== 1'b0 || bus.lo !== 32'h0) begin
      errors++; $display("FAIL reset_abort got activity=%b lo=%h want 0/0", saw_done, bus.lo);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset;
    test_multu;
    test_signed;
    test_div_zero;
    test_busy_ignore;
    test_overflow;
    test_back_to_back;
    test_noop;
    test_reset_mid;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
- Iterative HI/LO multiply/divide unit for the MIPS datapath.
- Sits directly downstream of the register file and consumes its two read ports (rs/rt operand values) for MULT, MULTU, DIV, DIVU, MTHI and MTLO.
- Holds the architectural HI/LO registers that MFHI/MFLO read.
- Exposes busy so control can stall.

Parameters:
- WIDTH, 32, operand width; HI and LO are each WIDTH bits; the iteration count equals WIDTH.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset, asynchronous, active-high.
- start  input  1  request; sampled only when busy=0.
- op  input  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO; 110/111 are no-ops.
- rs_data  input  WIDTH  multiplicand / dividend / MTHI-MTLO source (register-file regSource).
- rt_data  input  WIDTH  multiplier / divisor (register-file regTarget).
- busy  output  1  operation in progress; start is ignored while high.
- done  output  1  one-cycle pulse when an operation retires.
- div_by_zero  output  1  high with done when a DIV/DIVU had rt_data=0; cleared on the next accepted start.
- hi  output  WIDTH  committed HI register.
- lo  output  WIDTH  committed LO register.

Behaviour:
- Reset (asynchronous, any state, including mid-operation):
  - Clears HI, LO, busy, done, div_by_zero and the counter to 0.
  - State returns to IDLE.
  - Any in-flight operation is aborted with no HI/LO update.
- States: IDLE, MUL, DIV, FIX, DZ.
- IDLE, start=1, op=MTHI/MTLO:
  - HI (or LO) <= rs_data at that edge.
  - busy stays 0; no done pulse.
- IDLE, start=1, op=MULT/MULTU/DIV/DIVU (edge 0):
  - Latch operand magnitudes. For signed ops take the absolute value of each operand and record the result signs. For unsigned ops use the raw values.
  - counter <= 0; busy <= 1; div_by_zero <= 0.
  - Go to MUL or DIV.
  - If the op is DIV/DIVU and rt_data=0, go to DZ instead.
- MUL:
  - One shift-add step per cycle on a 2*WIDTH accumulator.
  - After WIDTH steps (edges 1..WIDTH), go to FIX.
- DIV:
  - One restoring-division step per cycle: shift the remainder left, trial-subtract the divisor, set the quotient bit.
  - After WIDTH steps (edges 1..WIDTH), go to FIX.
- FIX (edge WIDTH+1):
  - Apply sign correction. MULT: negate the 64-bit product if the operand signs differ. DIV: negate the quotient if the signs differ; the remainder takes the dividend's sign.
  - Commit HI/LO. Multiply: HI = product[2W-1:W], LO = product[W-1:0]. Divide: LO = quotient, HI = remainder.
  - busy <= 0; done <= 1 for exactly one cycle; return to IDLE.
- DZ (edge 1):
  - HI/LO unchanged; done <= 1; div_by_zero <= 1; busy <= 0; return to IDLE.
- Latency: busy is high for WIDTH+1 cycles (33 at default). HI/LO are valid in the cycle in which done=1.
- Signed division truncates toward zero.
- Overflow case 0x80000000 / 0xFFFFFFFF (DIV): LO = 0x80000000, HI = 0; no flag.
- start while busy=1: ignored. Operands, op and HI/LO are unaffected.
- start=1 in the same cycle done=1: accepted, because busy is already 0.
- op 110/111 with start=1: no state change, no busy.
- hi/lo are driven directly from registers, with no combinational path from the inputs.

Test Plan:
- Reset, then MULTU rs=0xFFFFFFFF, rt=0xFFFFFFFF -> busy for 33 cycles, then done pulse; HI=0xFFFFFFFE, LO=0x00000001.
- MULT rs=0xFFFFFFFD (-3), rt=5 -> HI=0xFFFFFFFF, LO=0xFFFFFFF1; then DIV rs=0xFFFFFFF9 (-7), rt=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- MTHI rs=0x12345678, then DIVU rs=10, rt=0 -> busy for 1 cycle; done=1 and div_by_zero=1; HI=0x12345678 unchanged.
- DIVU rs=100, rt=7; pulse start with MULTU 2*3 at cycle 5 -> second request ignored; final LO=14, HI=2.
- DIV rs=0x80000000, rt=0xFFFFFFFF -> LO=0x80000000, HI=0.
- MTLO 0xAA; start MULTU 4*4; assert rst at cycle 10 -> immediately HI=LO=0, busy=0; no done pulse follows.
